// File: rtl/univ_shift_reg.sv
// Universal shift/rotate register: parallel load plus multi-cycle counted
// shift/rotate operations, with a busy flag and a one-cycle done pulse.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNTW-1:0]  amt,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting; ld loads q, start latches mode/count
    // SHIFT | one step per edge, counter counts down to the last step
    // DONE  | one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] M_SLL = 3'b001;
    localparam logic [2:0] M_SRL = 3'b010;
    localparam logic [2:0] M_SRA = 3'b011;
    localparam logic [2:0] M_ROL = 3'b100;
    localparam logic [2:0] M_ROR = 3'b101;

    localparam logic [CNTW-1:0] WIDTH_C = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              sout_q, sout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        mode_q, mode_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              is_shift;

    assign is_shift = (mode == M_SLL) || (mode == M_SRL) || (mode == M_SRA);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ld) begin
                    q_d = d;
                end else if (start) begin
                    mode_d = mode;
                    // Shifts past WIDTH steps cannot change q further; rotates keep the full count.
                    cnt_d  = (is_shift && (amt > WIDTH_C)) ? WIDTH_C : amt;
                    state_d = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                case (mode_q)
                    M_SLL: begin
                        q_d    = {q_q[WIDTH-2:0], sin};
                        sout_d = q_q[WIDTH-1];
                    end
                    M_SRL: begin
                        q_d    = {sin, q_q[WIDTH-1:1]};
                        sout_d = q_q[0];
                    end
                    M_SRA: begin
                        q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                        sout_d = q_q[0];
                    end
                    M_ROL: begin
                        q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        sout_d = q_q[WIDTH-1];
                    end
                    M_ROR: begin
                        q_d    = {q_q[0], q_q[WIDTH-1:1]};
                        sout_d = q_q[0];
                    end
                    default: ;
                endcase
                cnt_d = cnt_q - ONE_C;
                if (cnt_q == ONE_C) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with hand-computed expectations.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNTW  = 4;

    logic             clk;
    logic             reset;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [2:0]       mode;
    logic [CNTW-1:0]  amt;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;

    univ_shift_reg #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .ld    (ld),
        .d     (d),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .sin   (sin),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic es,
                           input logic eb, input logic ed);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".sout"}, 32'(sout), 32'(es));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    logic [7:0] rot_exp [12] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06,
                                 8'h03, 8'h81, 8'hC0, 8'h60, 8'h30, 8'h18};
    logic [7:0] srl_exp [8]  = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

    initial begin
        reset = 1'b0; ld = 1'b0; d = '0; start = 1'b0; mode = '0; amt = '0; sin = 1'b0;

        // Reset held two edges, then load A5
        tick(); tick();
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; ld = 1'b1; d = 8'hA5;
        tick();
        chk_all("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        ld = 1'b0;
        tick();
        chk_all("idle_hold", 8'hA5, 1'b0, 1'b0, 1'b0);

        // SLL by 3
        start = 1'b1; mode = 3'b001; amt = 4'd3; sin = 1'b0;
        tick();
        chk_all("sll.start", 8'hA5, 1'b0, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b111; amt = 4'd0;
        tick();
        chk_all("sll.s1", 8'h4A, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("sll.s2", 8'h94, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("sll.s3", 8'h28, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("sll.after", 8'h28, 1'b1, 1'b0, 1'b0);

        // SRA by 2, with ld asserted during SHIFT/DONE (ignored)
        ld = 1'b1; d = 8'h85;
        tick();
        chk("sra.load", 32'(q), 32'h85);
        ld = 1'b0; start = 1'b1; mode = 3'b011; amt = 4'd2;
        tick();
        chk_all("sra.start", 8'h85, 1'b1, 1'b1, 1'b0);
        start = 1'b0; ld = 1'b1; d = 8'h00;
        tick();
        chk_all("sra.s1", 8'hC2, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("sra.s2", 8'hE1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("sra.after", 8'hE1, 1'b0, 1'b0, 1'b0);

        // ROR by 12, unclamped
        ld = 1'b1; d = 8'h81;
        tick();
        chk("ror.load", 32'(q), 32'h81);
        ld = 1'b0; start = 1'b1; mode = 3'b101; amt = 4'd12;
        tick();
        chk("ror.start.busy", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("ror.s%0d.q", i + 1), 32'(q), 32'(rot_exp[i]));
            chk($sformatf("ror.s%0d.busy", i + 1), 32'(busy), (i < 11) ? 32'd1 : 32'd0);
            chk($sformatf("ror.s%0d.done", i + 1), 32'(done), (i < 11) ? 32'd0 : 32'd1);
        end
        chk("ror.final.sout", 32'(sout), 32'd0);
        tick();
        chk_all("ror.after", 8'h18, 1'b0, 1'b0, 1'b0);

        // SRL with amt=15 saturates at 8 steps
        ld = 1'b1; d = 8'hFF;
        tick();
        ld = 1'b0; start = 1'b1; mode = 3'b010; amt = 4'd15; sin = 1'b0;
        tick();
        chk("srl.start.busy", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("srl.s%0d.q", i + 1), 32'(q), 32'(srl_exp[i]));
            chk($sformatf("srl.s%0d.busy", i + 1), 32'(busy), (i < 7) ? 32'd1 : 32'd0);
            chk($sformatf("srl.s%0d.done", i + 1), 32'(done), (i < 7) ? 32'd0 : 32'd1);
        end
        chk("srl.final.sout", 32'(sout), 32'd1);
        tick();
        chk_all("srl.after", 8'h00, 1'b1, 1'b0, 1'b0);

        // amt=0: straight to DONE
        ld = 1'b1; d = 8'hFF;
        tick();
        ld = 1'b0; start = 1'b1; mode = 3'b001; amt = 4'd0;
        tick();
        chk_all("amt0.done", 8'hFF, 1'b1, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        chk_all("amt0.after", 8'hFF, 1'b1, 1'b0, 1'b0);

        // Mode 110 runs counted cycles with q/sout unchanged
        ld = 1'b1; d = 8'h3C;
        tick();
        ld = 1'b0; start = 1'b1; mode = 3'b110; amt = 4'd2; sin = 1'b1;
        tick();
        chk_all("nop.start", 8'h3C, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk_all("nop.s1", 8'h3C, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("nop.s2", 8'h3C, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("nop.after", 8'h3C, 1'b1, 1'b0, 1'b0);

        // Reset during step 2 of an amt=5 shift aborts it
        ld = 1'b1; d = 8'h0F;
        tick();
        ld = 1'b0; start = 1'b1; mode = 3'b001; amt = 4'd5; sin = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_all("abort.s1", 8'h1F, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        chk_all("abort.rst", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("abort.nodone%0d", i), 32'(done), 32'd0);
            chk($sformatf("abort.nobusy%0d", i), 32'(busy), 32'd0);
        end

        // ld and start together: load wins
        ld = 1'b1; d = 8'h5A; start = 1'b1; mode = 3'b001; amt = 4'd3;
        tick();
        chk_all("ldstart", 8'h5A, 1'b0, 1'b0, 1'b0);
        ld = 1'b0; start = 1'b0;
        tick();
        chk_all("ldstart.after", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Reset pulse between edges has no effect
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        chk_all("rst_glitch", 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 8, register width in bits (>=2).
REQ-002 SHALL have parameter: CNTW, $clog2(WIDTH)+1, width of shift-amount input.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 SHALL have port: ld  input  1  parallel-load request.
REQ-006 SHALL have port: d  input  WIDTH  parallel-load data.
REQ-007 SHALL have port: start  input  1  begin a multi-cycle shift/rotate operation.
REQ-008 SHALL have port: mode  input  3  operation select, sampled with start.
REQ-009 SHALL have port: amt  input  CNTW  number of single-bit steps, sampled with start.
REQ-010 SHALL have port: sin  input  1  serial fill bit for logical shifts, sampled every step.
REQ-011 SHALL have port: q  output  WIDTH  register contents.
REQ-012 SHALL have port: sout  output  1  last bit shifted/rotated out.
REQ-013 SHALL have port: busy  output  1  operation in progress.
REQ-014 SHALL have port: done  output  1  single-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DONE; all outputs registered.
REQ-016 In IDLE with ld=1, q SHALL take d at that edge; state stays IDLE; start ignored (ld wins).
REQ-017 In IDLE with ld=0 and start=0, q, sout SHALL hold.
REQ-018 In IDLE with start=1, ld=0: SHALL latch mode and step count, go to SHIFT, q unchanged that edge.
REQ-019 Modes: 000 hold-op, 001 shift left logical, 010 shift right logical, 011 shift right arithmetic, 100 rotate left, 101 rotate right, 110/111 treated as 000.
REQ-020 Each edge in SHIFT SHALL perform one step per latched mode and decrement the step counter; sout gets the bit leaving q (rotates: bit wrapping around).
REQ-021 Logical shifts SHALL fill the vacated bit with sin; arithmetic right SHALL replicate q[WIDTH-1].
REQ-022 Step count for shift modes (001-011) SHALL saturate at WIDTH; rotate modes SHALL execute the full amt steps unclamped.
REQ-023 Mode 000/110/111 SHALL run the counted cycles with q and sout unchanged.
REQ-024 On the edge performing the final step, state SHALL go to DONE; in DONE, done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-025 busy SHALL be 1 exactly while state is SHIFT; busy and done never both 1.
REQ-026 amt=0 at start SHALL go IDLE->DONE directly (no SHIFT), q unchanged, done pulses one cycle.
REQ-027 ld, start, mode, amt SHALL be ignored in SHIFT and DONE.
REQ-028 Latency: start at edge N with amt=k>0 -> steps at edges N+1..N+k, done high for cycle after edge N+k.

Reset
REQ-029 reset=0 at a rising edge SHALL force q=0, sout=0, busy=0, done=0, counter=0, state IDLE, overriding ld/start.
REQ-030 reset=0 mid-SHIFT SHALL abort the operation; no done pulse is generated for it.
REQ-031 Reset SHALL have no effect between clock edges.

Verification (WIDTH=8)
REQ-032 Hold reset=0 two edges -> q=00, sout=0, busy=0, done=0; release, ld=1 d=A5 -> q=A5 next edge.
REQ-033 q=A5, start mode=001 amt=3 sin=0 -> busy 3 cycles, q=4A,94,28, sout=1, then done pulse one cycle.
REQ-034 q=85, start mode=011 amt=2 -> q=C2,E1, sout=0; q=81, mode=101 amt=12 -> busy 12 cycles, final q=18.
REQ-035 q=FF, mode=010 amt=15 sin=0 -> 8 steps only, q=00, busy 8 cycles; amt=0 -> done next cycle, busy never 1, q=FF.
REQ-036 reset=0 during step 2 of amt=5 shift -> q=00, busy=0, no done; ld and start together in IDLE -> load only, busy stays 0.
